// File: rtl/mac_exec_stage.sv
// Execute/writeback stage of the mixer DSP core: fixed-point multiply, add/sub and
// accumulator ops with a 3-cycle issue-to-writeback latency and read-after-write hazard reporting.
module mac_exec_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int REGADDR_WIDTH = 5,
    parameter int FRAC_BITS     = 24,
    parameter int ACC_WIDTH     = 72
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [2:0]               in_op,
    input  logic [REGADDR_WIDTH-1:0] in_dest,
    input  logic [REGADDR_WIDTH-1:0] in_addr_a,
    input  logic [REGADDR_WIDTH-1:0] in_addr_b,
    input  logic [DATA_WIDTH-1:0]    dataA,
    input  logic [DATA_WIDTH-1:0]    dataB,
    input  logic                     flags_clr,
    output logic                     wb_en,
    output logic [REGADDR_WIDTH-1:0] wb_addr,
    output logic [DATA_WIDTH-1:0]    wb_data,
    output logic                     hazard,
    output logic                     hazard_err,
    output logic                     sat_flag
);

    localparam int PW = 2 * DATA_WIDTH;
    // One guard bit above the accumulator holds every intermediate without wrapping.
    localparam int XW = ACC_WIDTH + 1;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MUL   = 3'd1,
        OP_MAC   = 3'd2,
        OP_MSUB  = 3'd3,
        OP_ADD   = 3'd4,
        OP_SUB   = 3'd5,
        OP_ACCW  = 3'd6,
        OP_ACCLD = 3'd7
    } op_e;

    function automatic logic op_writes(input op_e op);
        return (op == OP_MUL) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_ACCW);
    endfunction

    // Returns {clipped, value} saturated to the DATA_WIDTH signed range.
    function automatic logic [DATA_WIDTH:0] sat_data(input logic signed [XW-1:0] x);
        logic signed [XW-1:0] max_v;
        logic signed [XW-1:0] min_v;
        max_v = {{(XW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
        min_v = {{(XW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
        if (x > max_v) begin
            sat_data = {1'b1, max_v[DATA_WIDTH-1:0]};
        end else if (x < min_v) begin
            sat_data = {1'b1, min_v[DATA_WIDTH-1:0]};
        end else begin
            sat_data = {1'b0, x[DATA_WIDTH-1:0]};
        end
    endfunction

    // Stage 1: op/dest captured at issue
    logic                     s1_valid_q, s1_valid_d;
    op_e                      s1_op_q, s1_op_d;
    logic [REGADDR_WIDTH-1:0] s1_dest_q, s1_dest_d;

    // Stage 2: operands and full-precision product
    logic                     s2_valid_q, s2_valid_d;
    op_e                      s2_op_q, s2_op_d;
    logic [REGADDR_WIDTH-1:0] s2_dest_q, s2_dest_d;
    logic [DATA_WIDTH-1:0]    s2_a_q, s2_a_d;
    logic [DATA_WIDTH-1:0]    s2_b_q, s2_b_d;
    logic signed [PW-1:0]     s2_prod_q, s2_prod_d;

    // Stage 3: writeback port, accumulator and sticky flags
    logic                        wb_en_q, wb_en_d;
    logic [REGADDR_WIDTH-1:0]    wb_addr_q, wb_addr_d;
    logic [DATA_WIDTH-1:0]       wb_data_q, wb_data_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        sat_flag_q, sat_flag_d;
    logic                        hazard_err_q, hazard_err_d;

    logic signed [PW-1:0] a_wide;
    logic signed [PW-1:0] b_wide;

    always_comb begin
        s1_valid_d = in_valid;
        s1_op_d    = op_e'(in_op);
        s1_dest_d  = in_dest;

        a_wide     = {{DATA_WIDTH{dataA[DATA_WIDTH-1]}}, dataA};
        b_wide     = {{DATA_WIDTH{dataB[DATA_WIDTH-1]}}, dataB};
        s2_valid_d = s1_valid_q;
        s2_op_d    = s1_op_q;
        s2_dest_d  = s1_dest_q;
        s2_a_d     = dataA;
        s2_b_d     = dataB;
        s2_prod_d  = a_wide * b_wide;
    end

    logic signed [XW-1:0] prod_x;
    logic signed [XW-1:0] a_x;
    logic signed [XW-1:0] b_x;
    logic signed [XW-1:0] acc_x;
    logic signed [XW-1:0] acc_sum;
    logic signed [XW-1:0] res_pre;
    logic [DATA_WIDTH:0]  res_sat;
    logic                 res_wr;
    logic                 acc_clip;
    logic                 sat_event;

    always_comb begin
        prod_x  = {{(XW-PW){s2_prod_q[PW-1]}}, s2_prod_q};
        a_x     = {{(XW-DATA_WIDTH){s2_a_q[DATA_WIDTH-1]}}, s2_a_q};
        b_x     = {{(XW-DATA_WIDTH){s2_b_q[DATA_WIDTH-1]}}, s2_b_q};
        acc_x   = {acc_q[ACC_WIDTH-1], acc_q};
        acc_sum = (s2_op_q == OP_MSUB) ? (acc_x - prod_x) : (acc_x + prod_x);

        res_pre   = '0;
        res_wr    = 1'b0;
        acc_clip  = 1'b0;
        acc_d     = acc_q;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;

        if (s2_valid_q) begin
            case (s2_op_q)
                OP_MUL: begin
                    res_pre = prod_x >>> FRAC_BITS;
                    res_wr  = 1'b1;
                end
                OP_ADD: begin
                    res_pre = a_x + b_x;
                    res_wr  = 1'b1;
                end
                OP_SUB: begin
                    res_pre = a_x - b_x;
                    res_wr  = 1'b1;
                end
                OP_ACCW: begin
                    res_pre = acc_x >>> FRAC_BITS;
                    res_wr  = 1'b1;
                end
                OP_MAC, OP_MSUB: begin
                    // Guard bit disagreeing with the accumulator sign bit means overflow.
                    if (acc_sum[XW-1] != acc_sum[XW-2]) begin
                        acc_clip = 1'b1;
                        acc_d    = acc_sum[XW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                                 : {1'b0, {(ACC_WIDTH-1){1'b1}}};
                    end else begin
                        acc_d = acc_sum[ACC_WIDTH-1:0];
                    end
                end
                OP_ACCLD: acc_d = prod_x[ACC_WIDTH-1:0];
                default: ;
            endcase
        end

        res_sat   = sat_data(res_pre);
        sat_event = (res_wr && res_sat[DATA_WIDTH]) || acc_clip;

        if (res_wr && (s2_dest_q != '0)) begin
            wb_en_d   = 1'b1;
            wb_addr_d = s2_dest_q;
            wb_data_d = res_sat[DATA_WIDTH-1:0];
        end
    end

    // In-flight writers: S1, S2, and the op currently on the write port.
    logic [2:0]               pend_wr;
    logic [REGADDR_WIDTH-1:0] pend_dest [3];
    logic [2:0]               hit_a;
    logic [2:0]               hit_b;

    always_comb begin
        pend_wr[0]   = s1_valid_q && op_writes(s1_op_q);
        pend_dest[0] = s1_dest_q;
        pend_wr[1]   = s2_valid_q && op_writes(s2_op_q);
        pend_dest[1] = s2_dest_q;
        pend_wr[2]   = wb_en_q;
        pend_dest[2] = wb_addr_q;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_hazard
            assign hit_a[gi] = pend_wr[gi] && (pend_dest[gi] == in_addr_a);
            assign hit_b[gi] = pend_wr[gi] && (pend_dest[gi] == in_addr_b);
        end
    endgenerate

    assign hazard = in_valid && (((in_addr_a != '0) && (|hit_a)) ||
                                 ((in_addr_b != '0) && (|hit_b)));

    // A set event in the same cycle as flags_clr leaves the flag set.
    always_comb begin
        sat_flag_d   = sat_event || (sat_flag_q && !flags_clr);
        hazard_err_d = hazard || (hazard_err_q && !flags_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_op_q      <= OP_NOP;
            s1_dest_q    <= '0;
            s2_valid_q   <= 1'b0;
            s2_op_q      <= OP_NOP;
            s2_dest_q    <= '0;
            s2_a_q       <= '0;
            s2_b_q       <= '0;
            s2_prod_q    <= '0;
            wb_en_q      <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            acc_q        <= '0;
            sat_flag_q   <= 1'b0;
            hazard_err_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_op_q      <= s1_op_d;
            s1_dest_q    <= s1_dest_d;
            s2_valid_q   <= s2_valid_d;
            s2_op_q      <= s2_op_d;
            s2_dest_q    <= s2_dest_d;
            s2_a_q       <= s2_a_d;
            s2_b_q       <= s2_b_d;
            s2_prod_q    <= s2_prod_d;
            wb_en_q      <= wb_en_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
            acc_q        <= acc_d;
            sat_flag_q   <= sat_flag_d;
            hazard_err_q <= hazard_err_d;
        end
    end

    assign wb_en      = wb_en_q;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;
    assign sat_flag   = sat_flag_q;
    assign hazard_err = hazard_err_q;

endmodule

// File: tb/tb_mac_exec_stage.sv
// Self-checking bench for mac_exec_stage: directed vector table, hand-written corner
// sequences and randomized traffic checked against a wide-integer reference model.
module tb_mac_exec_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int FB = 24;
    localparam int ACCW_BITS = 72;

    localparam logic signed [127:0] DMAX = 128'sd2147483647;
    localparam logic signed [127:0] DMIN = -128'sd2147483648;
    localparam logic signed [127:0] AMAX = (128'sd1 <<< (ACCW_BITS - 1)) - 128'sd1;
    localparam logic signed [127:0] AMIN = -(128'sd1 <<< (ACCW_BITS - 1));

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [2:0]    in_op;
    logic [AW-1:0] in_dest, in_addr_a, in_addr_b;
    logic [DW-1:0] dataA, dataB;
    logic          flags_clr;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          hazard, hazard_err, sat_flag;

    mac_exec_stage #(
        .DATA_WIDTH(DW), .REGADDR_WIDTH(AW), .FRAC_BITS(FB), .ACC_WIDTH(ACCW_BITS)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op), .in_dest(in_dest),
        .in_addr_a(in_addr_a), .in_addr_b(in_addr_b), .dataA(dataA), .dataB(dataB),
        .flags_clr(flags_clr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .hazard(hazard), .hazard_err(hazard_err), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [2:0]  op;
        logic [4:0]  dest;
        logic [31:0] a;
        logic [31:0] b;
    } pend_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        sat;
    } vec_t;

    pend_t              pq[$];
    logic signed [127:0] m_acc;
    logic               m_wb_en, m_sat, m_herr;
    logic [4:0]         m_wb_addr;
    logic [31:0]        m_wb_data;
    logic               herr_set, prev_clr;
    logic [31:0]        nxt_a, nxt_b;
    int                 cyc;
    int                 checks = 0;
    int                 errors = 0;

    logic        s_en, s_haz, s_herr, s_sat;
    logic [4:0]  s_addr;
    logic [31:0] s_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic is_writer(input logic [2:0] op);
        return (op == 3'd1) || (op == 3'd4) || (op == 3'd5) || (op == 3'd6);
    endfunction

    // An op issued in one of the three previous cycles that will write x is still in flight.
    function automatic logic model_hit(input logic [4:0] x);
        if (x == 5'd0) return 1'b0;
        foreach (pq[i]) begin
            if (pq[i].due >= cyc && pq[i].due <= cyc + 2 && pq[i].dest == x && is_writer(pq[i].op))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        pq.delete();
        m_acc = '0; m_wb_en = 1'b0; m_wb_addr = '0; m_wb_data = '0;
        m_sat = 1'b0; m_herr = 1'b0; herr_set = 1'b0; prev_clr = 1'b0;
    endtask

    // Retire every op whose result becomes visible in the current cycle.
    task automatic model_advance();
        logic sat_ev, wr;
        logic signed [127:0] sa, sb, p, r, t;
        sat_ev  = 1'b0;
        m_wb_en = 1'b0;
        foreach (pq[i]) begin
            if (pq[i].due == cyc) begin
                sa = {{96{pq[i].a[31]}}, pq[i].a};
                sb = {{96{pq[i].b[31]}}, pq[i].b};
                p  = sa * sb;
                wr = 1'b0;
                r  = '0;
                case (pq[i].op)
                    3'd1: begin r = p >>> FB; wr = 1'b1; end
                    3'd4: begin r = sa + sb;  wr = 1'b1; end
                    3'd5: begin r = sa - sb;  wr = 1'b1; end
                    3'd6: begin r = m_acc >>> FB; wr = 1'b1; end
                    3'd2, 3'd3: begin
                        t = (pq[i].op == 3'd2) ? m_acc + p : m_acc - p;
                        if (t > AMAX) begin t = AMAX; sat_ev = 1'b1; end
                        else if (t < AMIN) begin t = AMIN; sat_ev = 1'b1; end
                        m_acc = t;
                    end
                    3'd7: m_acc = p;
                    default: ;
                endcase
                if (wr) begin
                    if (r > DMAX) begin r = DMAX; sat_ev = 1'b1; end
                    else if (r < DMIN) begin r = DMIN; sat_ev = 1'b1; end
                    if (pq[i].dest != 5'd0) begin
                        m_wb_en = 1'b1; m_wb_addr = pq[i].dest; m_wb_data = r[31:0];
                    end
                end
            end
        end
        m_sat  = sat_ev ? 1'b1 : (prev_clr ? 1'b0 : m_sat);
        m_herr = herr_set ? 1'b1 : (prev_clr ? 1'b0 : m_herr);
        while (pq.size() > 0 && pq[0].due < cyc) void'(pq.pop_front());
    endtask

    // One clock cycle: drive issue inputs (operands of the previous issue on dataA/B),
    // compare every output with the model at the falling edge, then step the model.
    task automatic tick(input logic v, input logic [2:0] op, input logic [4:0] dst,
                        input logic [4:0] aa, input logic [4:0] ab,
                        input logic [31:0] a, input logic [31:0] b, input logic clr);
        logic  eh;
        pend_t e;
        in_valid = v; in_op = op; in_dest = dst; in_addr_a = aa; in_addr_b = ab;
        flags_clr = clr; dataA = nxt_a; dataB = nxt_b;
        eh = v && (model_hit(aa) || model_hit(ab));
        @(negedge clk);
        s_en = wb_en; s_addr = wb_addr; s_data = wb_data;
        s_haz = hazard; s_herr = hazard_err; s_sat = sat_flag;
        chk("hazard", s_haz, eh);
        chk("wb_en", s_en, m_wb_en);
        chk("wb_addr", s_addr, m_wb_addr);
        chk("wb_data", s_data, m_wb_data);
        chk("sat_flag", s_sat, m_sat);
        chk("hazard_err", s_herr, m_herr);
        if (v) begin
            e.due = cyc + 3; e.op = op; e.dest = dst; e.a = a; e.b = b;
            pq.push_back(e);
        end
        herr_set = v && eh;
        prev_clr = clr;
        nxt_a = v ? a : $urandom();
        nxt_b = v ? b : $urandom();
        @(posedge clk);
        #1;
        cyc++;
        model_advance();
    endtask

    task automatic issue(input logic [2:0] op, input logic [4:0] dst, input logic [4:0] aa,
                         input logic [4:0] ab, input logic [31:0] a, input logic [31:0] b,
                         input logic clr);
        tick(1'b1, op, dst, aa, ab, a, b, clr);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
    endtask

    function automatic logic [31:0] rnd_data();
        case ($urandom_range(0, 5))
            0: return 32'h7FFFFFFF;
            1: return 32'h80000000;
            2: return 32'($urandom_range(0, 255));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    vec_t       vt[10];
    logic [2:0] zops[4];

    initial begin
        vt[0] = '{3'd1, 32'h00800000, 32'h00800000, 5'd3,  1'b1, 5'd3,  32'h00400000, 1'b0};
        vt[1] = '{3'd4, 32'h7FFFFFFF, 32'h00000001, 5'd7,  1'b1, 5'd7,  32'h7FFFFFFF, 1'b1};
        vt[2] = '{3'd5, 32'h80000000, 32'h00000001, 5'd8,  1'b1, 5'd8,  32'h80000000, 1'b1};
        vt[3] = '{3'd1, 32'hFF800000, 32'h00800000, 5'd9,  1'b1, 5'd9,  32'hFFC00000, 1'b0};
        vt[4] = '{3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd10, 1'b1, 5'd10, 32'h7FFFFFFF, 1'b1};
        vt[5] = '{3'd1, 32'hFFFFFFFF, 32'h00000001, 5'd11, 1'b1, 5'd11, 32'hFFFFFFFF, 1'b0};
        vt[6] = '{3'd4, 32'h00000005, 32'h00000007, 5'd1,  1'b1, 5'd1,  32'h0000000C, 1'b0};
        vt[7] = '{3'd5, 32'h00000003, 32'h0000000A, 5'd2,  1'b1, 5'd2,  32'hFFFFFFF9, 1'b0};
        vt[8] = '{3'd1, 32'h80000000, 32'h7FFFFFFF, 5'd12, 1'b1, 5'd12, 32'h80000000, 1'b1};
        vt[9] = '{3'd1, 32'h00800000, 32'h00800000, 5'd0,  1'b0, 5'd12, 32'h80000000, 1'b0};
        zops[0] = 3'd1; zops[1] = 3'd4; zops[2] = 3'd5; zops[3] = 3'd6;

        reset = 1'b1; in_valid = 1'b1; in_op = 3'd1; in_dest = 5'd0;
        in_addr_a = 5'd1; in_addr_b = 5'd2; dataA = '0; dataB = '0; flags_clr = 1'b0;
        nxt_a = '0; nxt_b = '0; cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_wb_en", wb_en, 1'b0);
        chk("reset_wb_addr", wb_addr, 5'd0);
        chk("reset_wb_data", wb_data, 32'd0);
        chk("reset_hazard", hazard, 1'b0);
        chk("reset_hazard_err", hazard_err, 1'b0);
        chk("reset_sat_flag", sat_flag, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Isolated single ops: result visible in T+3 only
        for (int i = 0; i < 10; i++) begin
            issue(vt[i].op, vt[i].dest, 5'd0, 5'd0, vt[i].a, vt[i].b, 1'b1);
            idle(3);
            chk("tbl_wb_en", s_en, vt[i].en);
            chk("tbl_wb_addr", s_addr, vt[i].addr);
            chk("tbl_wb_data", s_data, vt[i].data);
            chk("tbl_sat_flag", s_sat, vt[i].sat);
            idle(1);
            chk("tbl_single_pulse", s_en, 1'b0);
        end

        // Sticky sat flag: set beats a simultaneous clear, then a clear alone wins
        issue(3'd4, 5'd6, 5'd0, 5'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1);
        idle(1);
        tick(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1);
        idle(1);
        chk("sat_set_wins", s_sat, 1'b1);
        tick(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1);
        idle(1);
        chk("sat_cleared", s_sat, 1'b0);

        // Back-to-back accumulator chain: 1.0 + 0.5 - 0.25
        issue(3'd7, 5'd0, 5'd0, 5'd0, 32'h01000000, 32'h01000000, 1'b0);
        issue(3'd2, 5'd0, 5'd0, 5'd0, 32'h01000000, 32'h00800000, 1'b0);
        issue(3'd3, 5'd0, 5'd0, 5'd0, 32'h00400000, 32'h01000000, 1'b0);
        issue(3'd6, 5'd5, 5'd0, 5'd0, $urandom(), $urandom(), 1'b0);
        idle(3);
        chk("accw_en", s_en, 1'b1);
        chk("accw_addr", s_addr, 5'd5);
        chk("accw_data", s_data, 32'h01400000);

        // Hazards against S1 (source A) and S2 (source B), then no-hazard cases
        issue(3'd1, 5'd4, 5'd0, 5'd0, $urandom(), $urandom(), 1'b1);
        issue(3'd4, 5'd0, 5'd4, 5'd0, $urandom(), $urandom(), 1'b0);
        chk("hazard_s1", s_haz, 1'b1);
        idle(1);
        chk("hazard_err_set", s_herr, 1'b1);
        issue(3'd1, 5'd4, 5'd0, 5'd0, $urandom(), $urandom(), 1'b1);
        idle(1);
        issue(3'd4, 5'd0, 5'd0, 5'd4, $urandom(), $urandom(), 1'b0);
        chk("hazard_s2_b", s_haz, 1'b1);
        tick(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1);
        issue(3'd1, 5'd0, 5'd0, 5'd0, $urandom(), $urandom(), 1'b0);
        issue(3'd4, 5'd0, 5'd0, 5'd0, $urandom(), $urandom(), 1'b0);
        chk("hazard_dest0", s_haz, 1'b0);
        issue(3'd1, 5'd4, 5'd0, 5'd0, $urandom(), $urandom(), 1'b0);
        idle(3);
        issue(3'd4, 5'd0, 5'd4, 5'd4, $urandom(), $urandom(), 1'b0);
        chk("hazard_gap", s_haz, 1'b0);
        idle(1);
        chk("hazard_err_clear", s_herr, 1'b0);

        // Writing ops to register 0 never pulse the write port
        for (int i = 0; i < 8; i++) begin
            if (i < 4) issue(zops[i], 5'd0, 5'd0, 5'd0, $urandom(), $urandom(), 1'b0);
            else idle(1);
            chk("dest0_wb_en", s_en, 1'b0);
        end

        // Accumulator saturation: repeated max products exceed the accumulator range
        tick(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1);
        issue(3'd7, 5'd0, 5'd0, 5'd0, 32'h80000000, 32'h80000000, 1'b0);
        for (int i = 0; i < 515; i++)
            issue(3'd2, 5'd0, 5'd0, 5'd0, 32'h80000000, 32'h80000000, 1'b0);
        issue(3'd6, 5'd13, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
        idle(3);
        chk("acc_sat_flag", s_sat, 1'b1);
        chk("acc_sat_accw", s_data, 32'h7FFFFFFF);

        // Reset with MULs in flight
        issue(3'd1, 5'd3, 5'd0, 5'd0, 32'h01000000, 32'h01000000, 1'b0);
        issue(3'd1, 5'd4, 5'd0, 5'd0, 32'h01000000, 32'h01000000, 1'b0);
        in_valid = 1'b1; in_op = 3'd1; in_dest = 5'd5; in_addr_a = 5'd3; in_addr_b = 5'd0;
        dataA = nxt_a; dataB = nxt_b; flags_clr = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_wb_en", wb_en, 1'b0);
        chk("async_rst_wb_addr", wb_addr, 5'd0);
        chk("async_rst_wb_data", wb_data, 32'd0);
        chk("async_rst_hazard", hazard, 1'b0);
        chk("async_rst_sat", sat_flag, 1'b0);
        chk("async_rst_herr", hazard_err, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc += 2;
        model_reset();
        nxt_a = '0; nxt_b = '0;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("rst_no_pulse", s_en, 1'b0);
        end
        issue(3'd6, 5'd6, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
        idle(3);
        chk("rst_acc_zero_en", s_en, 1'b1);
        chk("rst_acc_zero_data", s_data, 32'd0);
        issue(3'd1, 5'd9, 5'd0, 5'd0, 32'h01000000, 32'h02000000, 1'b0);
        idle(2);
        chk("post_rst_early", s_en, 1'b0);
        idle(1);
        chk("post_rst_en", s_en, 1'b1);
        chk("post_rst_addr", s_addr, 5'd9);
        chk("post_rst_data", s_data, 32'h02000000);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), rnd_data(), rnd_data(),
                 ($urandom_range(0, 19) == 0));
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
